// File: rtl/wb_ip_splitter.sv
// Wishbone splitter: one upstream slave port fanned out to NSLV IP blocks by address window.
// Optional status window at idx == NSLV when WB_SPLIT_STATUS_EN is defined.
module wb_ip_splitter #(
    parameter int NSLV    = 4,
    parameter int IDX_LSB = 16,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic [NSLV-1:0]      s_cyc_o,
    output logic [NSLV-1:0]      s_stb_o,
    output logic                 s_we_o,
    output logic [3:0]           s_sel_o,
    output logic [31:0]          s_adr_o,
    output logic [31:0]          s_dat_o,
    input  logic [32*NSLV-1:0]   s_dat_i,
    input  logic [NSLV-1:0]      s_ack_i,
    input  logic [NSLV-1:0]      s_irq_i,
    output logic [2:0]           irq_o,
    input  logic                 err_clr_i,
    output logic                 err_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [IDX_W:0]  NSLV_W   = NSLV[IDX_W:0];
    localparam logic [NSLV-1:0] SEL_ONE  = NSLV'(1);
    localparam logic [31:0]     DAT_UNMAP = 32'hDEAD_BEEF;
    localparam logic [31:0]     DAT_TOUT  = 32'hBADC_0FFE;

    state_t            state_q;
    logic [15:0]       cnt_q;
    logic [NSLV-1:0]   stb_q;
    logic              ack_q;
    logic [31:0]       dat_q;
    logic              err_q;
    logic [2:0]        irq_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [31:0]       adr_q;
    logic [31:0]       wdat_q;

    logic [IDX_W-1:0]  adr_idx;
    logic [IDX_W:0]    idx_ext;
    logic              ack_hit;
    logic [31:0]       rdata;
    logic [2:0]        irq_d;
    logic              status_hit;

`ifdef WB_SPLIT_STATUS_EN
    logic [15:0]       tcnt_q;
    logic [7:0]        last_err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       status_word;
    assign status_word = {tcnt_q, last_err_q, 7'b0, err_q};
    assign status_hit  = (idx_ext == NSLV_W);
`else
    assign status_hit  = 1'b0;
`endif

    assign adr_idx = wbs_adr_i[IDX_LSB +: IDX_W];
    assign idx_ext = {1'b0, adr_idx};
    // stb_q is one-hot on the selected slave, so masking gives the selected ack only
    assign ack_hit = |(s_ack_i & stb_q);

    always_comb begin
        rdata = '0;
        irq_d = '0;
        for (int j = 0; j < NSLV; j++) begin
            if (stb_q[j]) rdata = rdata | s_dat_i[32*j +: 32];
            if (j % 3 == 0) irq_d[0] = irq_d[0] | s_irq_i[j];
            if (j % 3 == 1) irq_d[1] = irq_d[1] | s_irq_i[j];
            if (j % 3 == 2) irq_d[2] = irq_d[2] | s_irq_i[j];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stb_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            err_q   <= 1'b0;
            irq_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
`ifdef WB_SPLIT_STATUS_EN
            tcnt_q     <= '0;
            last_err_q <= '0;
            idx_q      <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            irq_q <= irq_d;
            if (err_clr_i) err_q <= 1'b0;
            // set paths below are assigned later so they win over a same-cycle clear
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (wbs_cyc_i && wbs_stb_i) begin
                        we_q   <= wbs_we_i;
                        sel_q  <= wbs_sel_i;
                        adr_q  <= wbs_adr_i;
                        wdat_q <= wbs_dat_i;
                        if (status_hit) begin
`ifdef WB_SPLIT_STATUS_EN
                            dat_q <= status_word;
                            if (wbs_we_i && wbs_dat_i[0]) begin
                                err_q  <= 1'b0;
                                tcnt_q <= '0;
                            end
`endif
                            ack_q   <= 1'b1;
                            state_q <= RESP;
                        end else if (idx_ext < NSLV_W) begin
                            stb_q   <= SEL_ONE << adr_idx;
                            state_q <= REQ;
`ifdef WB_SPLIT_STATUS_EN
                            idx_q   <= adr_idx;
`endif
                        end else begin
                            dat_q   <= DAT_UNMAP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= RESP;
`ifdef WB_SPLIT_STATUS_EN
                            last_err_q <= 8'(adr_idx);
`endif
                        end
                    end
                end
                REQ: begin
                    if (!wbs_cyc_i) begin
                        stb_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (ack_hit) begin
                        dat_q   <= rdata;
                        stb_q   <= '0;
                        ack_q   <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_q == TO_LAST) begin
                        dat_q   <= DAT_TOUT;
                        stb_q   <= '0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= RESP;
`ifdef WB_SPLIT_STATUS_EN
                        last_err_q <= 8'(idx_q);
                        if (tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign s_cyc_o   = stb_q;
    assign s_stb_o   = stb_q;
    assign s_we_o    = we_q;
    assign s_sel_o   = sel_q;
    assign s_adr_o   = adr_q;
    assign s_dat_o   = wdat_q;
    assign irq_o     = irq_q;
    assign err_o     = err_q;

endmodule
